axi_read_scheduler: RTL and testbench
=====================================

Name: axi_read_scheduler

Overview:
- Round-robin scheduler that shares the single AXI read channel (AR + R) among MASTERS read requesters (i-cache, d-cache refill, future prefetcher).
- Sits between the cache refill engines and the top-level AXI read ports.
- Keeps exactly one burst outstanding and routes returning beats to the granted requester.
- Checks burst length and ID, and flags protocol errors.

Parameters:
- MASTERS, 2, number of read requesters (2..8); master index is also the AXI ID.
- ADDR_WIDTH, 26, byte address width.
- DATA_WIDTH, 32, beat width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- m_arvalid  input  MASTERS  per-master read request valid.
- m_arready  output  MASTERS  per-master request accepted (one-cycle pulse).
- m_araddr  input  MASTERS*ADDR_WIDTH  per-master burst address; master i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_arlen  input  MASTERS*4  per-master burst length minus 1; master i occupies bits [i*4 +: 4].
- m_rvalid  output  MASTERS  beat valid to the owning master.
- m_rready  input  MASTERS  per-master beat ready.
- m_rlast  output  MASTERS  last beat to the owning master.
- m_rdata  output  DATA_WIDTH  beat data, shared by all masters.
- ARVALID  output  1  AXI read address valid.
- ARREADY  input  1  AXI read address ready.
- ARID  output  4  AXI ID, equal to the granted master index.
- ARLEN  output  4  AXI burst length minus 1.
- ARADDR  output  ADDR_WIDTH  AXI burst address.
- RVALID  input  1  AXI read data valid.
- RREADY  output  1  AXI read data ready.
- RLAST  input  1  AXI last beat.
- RID  input  4  AXI read ID.
- RDATA  input  DATA_WIDTH  AXI read data.
- busy  output  1  high whenever state is not IDLE.
- grant  output  3  index of the current or last granted master.
- proto_err  output  1  sticky protocol error flag.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, proto_err=0.
  - ARVALID, RREADY, all m_arready/m_rvalid/m_rlast, and busy are all 0.
  - ARADDR, ARLEN and ARID are 0.
- Reset mid-burst: state returns to IDLE immediately with no drain. Beats arriving afterwards are not accepted (RREADY=0).
- State IDLE:
  - Select the first i with m_arvalid[i]=1, scanning rr_ptr, rr_ptr+1, … modulo MASTERS.
  - Assert m_arready[i] combinationally for that cycle only.
  - Latch addr/len and set grant=i, then go to ADDR.
  - No requests: remain in IDLE.
  - RREADY=0 in IDLE.
- State ADDR:
  - ARVALID=1 with latched ARADDR/ARLEN and ARID=grant.
  - These values are held stable until ARREADY=1.
  - On the ARVALID&&ARREADY cycle: beat_cnt=0, go to DATA.
  - ARVALID first rises on the cycle after acceptance, so request-to-ARVALID latency is 1 cycle.
- State DATA:
  - RREADY = (RID==grant) ? m_rready[grant] : 1.
  - m_rvalid[grant] = RVALID && RID==grant. m_rlast[grant] = RLAST && RID==grant. All other masters' m_rvalid/m_rlast are 0.
  - m_rdata = RDATA in every state (it is a combinational pass-through).
  - Matching beat handshake: beat_cnt increments (4-bit, no wrap within a legal burst).
  - RLAST handshake with beat_cnt != latched len: set proto_err.
  - Beat handshake without RLAST when beat_cnt == len, i.e. the burst exceeds ARLEN+1 beats: set proto_err. Keep forwarding beats until RLAST arrives.
  - RVALID with RID!=grant: the beat is consumed and dropped (RREADY=1), it is not forwarded, and proto_err is set.
  - On the matching RLAST handshake: rr_ptr = (grant+1) mod MASTERS, go to IDLE.
- Bus turnaround and fairness:
  - After RLAST there is at least one IDLE cycle before the next m_arready.
  - A master holding m_arvalid is granted within MASTERS bursts.
- Simultaneous events:
  - A new request during ADDR/DATA waits.
  - Request deassertion before the grant is permitted, and the master is not granted.
  - m_arvalid from the granted master while it is in DATA is ignored until IDLE.
- proto_err is cleared only by rst.
- Timing: single clock domain; all outputs except m_arready/m_rvalid/m_rlast/RREADY/m_rdata are registered.

Test Plan:
- Single master 0 request, addr=0x0000100, len=3; ARREADY after 2 cycles; 4 beats D0..D3 with RLAST on D3 -> m_arready[0] pulses once; ARVALID holds stable for 3 cycles; m_rvalid[0] seen for 4 beats; m_rlast[0] on D3; proto_err=0; rr_ptr=1.
- Both masters request every cycle, len=0 -> grants alternate 0,1,0,1 over 4 bursts; each ARID matches its grant.
- Backpressure: m_rready[1]=0 for 3 cycles during the burst to master 1 -> RREADY=0 for those cycles; no beat lost; beat_cnt reaches len.
- Error cases, each run as a separate subcase:
  - RLAST arrives on beat 2 of a len=3 burst -> proto_err=1, state returns to IDLE.
  - A beat with RID=3 while grant=0 -> beat dropped, m_rvalid stays 0, proto_err=1.
- rst asserted in DATA mid-burst -> next cycle ARVALID=0, RREADY=0, busy=0, proto_err=0, grant=0.
- Master 1 lowers m_arvalid in the same cycle master 0's burst completes -> next grant goes to master 0 when it is requesting; with no requests the block stays IDLE.

Source files
------------

// File: rtl/axi_read_scheduler.sv
// Round-robin arbiter sharing one AXI read channel among several refill requesters.
// One burst is in flight at a time; returning beats are steered to the granted master.
module axi_read_scheduler #(
   parameter int MASTERS    = 2,
   parameter int ADDR_WIDTH = 26,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [MASTERS-1:0]            m_arvalid,
   output logic [MASTERS-1:0]            m_arready,
   input  logic [MASTERS*ADDR_WIDTH-1:0] m_araddr,
   input  logic [MASTERS*4-1:0]          m_arlen,
   output logic [MASTERS-1:0]            m_rvalid,
   input  logic [MASTERS-1:0]            m_rready,
   output logic [MASTERS-1:0]            m_rlast,
   output logic [DATA_WIDTH-1:0]         m_rdata,
   output logic                          ARVALID,
   input  logic                          ARREADY,
   output logic [3:0]                    ARID,
   output logic [3:0]                    ARLEN,
   output logic [ADDR_WIDTH-1:0]         ARADDR,
   input  logic                          RVALID,
   output logic                          RREADY,
   input  logic                          RLAST,
   input  logic [3:0]                    RID,
   input  logic [DATA_WIDTH-1:0]         RDATA,
   output logic                          busy,
   output logic [2:0]                    grant,
   output logic                          proto_err
);

   // state | meaning
   // IDLE  | pick next requester round-robin, pulse its m_arready
   // ADDR  | present latched burst on AR until ARREADY
   // DATA  | route matching beats to the granted master until RLAST
   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

   localparam logic [MASTERS-1:0] ONE_M = {{(MASTERS-1){1'b0}}, 1'b1};

   state_t                  state_q;
   logic [2:0]              rr_ptr_q;
   logic [2:0]              grant_q;
   logic [3:0]              beat_cnt_q;
   logic [3:0]              len_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    arvalid_q;
   logic                    proto_err_q;

   logic                    sel_valid;
   logic [2:0]              sel_idx;
   logic [3:0]              scan_idx;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [3:0]              sel_len;
   logic                    rid_match;
   logic                    own_rready;
   logic                    rready_c;
   logic                    beat_hs;
   logic                    own_hs;
   logic [2:0]              next_ptr;

   // Scan from the highest offset down so the nearest requester to rr_ptr wins.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = 3'd0;
      scan_idx  = 4'd0;
      for (int k = MASTERS-1; k >= 0; k--) begin
         scan_idx = {1'b0, rr_ptr_q} + 4'(k);
         if (scan_idx >= 4'(MASTERS))
            scan_idx = scan_idx - 4'(MASTERS);
         if (|(m_arvalid & (ONE_M << scan_idx))) begin
            sel_valid = 1'b1;
            sel_idx   = scan_idx[2:0];
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_len  = 4'd0;
      for (int i = 0; i < MASTERS; i++) begin
         if (sel_idx == 3'(i)) begin
            sel_addr = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_len  = m_arlen[i*4 +: 4];
         end
      end
   end

   assign rid_match  = (RID == {1'b0, grant_q});
   assign own_rready = |(m_rready & (ONE_M << grant_q));
   assign rready_c   = (state_q == ST_DATA) && (rid_match ? own_rready : 1'b1);
   assign beat_hs    = RVALID && rready_c;
   assign own_hs     = beat_hs && rid_match;
   assign next_ptr   = (grant_q == 3'(MASTERS-1)) ? 3'd0 : grant_q + 3'd1;

   assign m_arready = (state_q == ST_IDLE && sel_valid) ? (ONE_M << sel_idx) : '0;
   assign m_rvalid  = (state_q == ST_DATA && RVALID && rid_match) ? (ONE_M << grant_q) : '0;
   assign m_rlast   = (state_q == ST_DATA && RVALID && RLAST && rid_match) ? (ONE_M << grant_q) : '0;
   assign m_rdata   = RDATA;
   assign RREADY    = rready_c;
   assign ARVALID   = arvalid_q;
   assign ARADDR    = addr_q;
   assign ARLEN     = len_q;
   assign ARID      = {1'b0, grant_q};
   assign busy      = (state_q != ST_IDLE);
   assign grant     = grant_q;
   assign proto_err = proto_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= 3'd0;
         grant_q     <= 3'd0;
         beat_cnt_q  <= 4'd0;
         len_q       <= 4'd0;
         addr_q      <= '0;
         arvalid_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sel_valid) begin
                  grant_q   <= sel_idx;
                  addr_q    <= sel_addr;
                  len_q     <= sel_len;
                  arvalid_q <= 1'b1;
                  state_q   <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (ARREADY) begin
                  arvalid_q  <= 1'b0;
                  beat_cnt_q <= 4'd0;
                  state_q    <= ST_DATA;
               end
            end
            ST_DATA: begin
               // Foreign-ID beats are swallowed so they cannot stall the bus.
               if (RVALID && !rid_match)
                  proto_err_q <= 1'b1;
               if (own_hs) begin
                  if (RLAST) begin
                     if (beat_cnt_q != len_q)
                        proto_err_q <= 1'b1;
                     rr_ptr_q <= next_ptr;
                     state_q  <= ST_IDLE;
                  end else begin
                     if (beat_cnt_q == len_q)
                        proto_err_q <= 1'b1;
                     if (beat_cnt_q != 4'hF)
                        beat_cnt_q <= beat_cnt_q + 4'd1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_read_scheduler.sv
// Directed bench for axi_read_scheduler: stimulus tasks push expected AR/R
// transfers into queues, a negedge monitor pops and compares them.
module tb_axi_read_scheduler;
   localparam int M  = 2;
   localparam int AW = 26;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic [M-1:0]    m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
   logic [M*AW-1:0] m_araddr;
   logic [M*4-1:0]  m_arlen;
   logic [DW-1:0]   m_rdata;
   logic            ARVALID, ARREADY, RVALID, RREADY, RLAST;
   logic [3:0]      ARID, ARLEN, RID;
   logic [AW-1:0]   ARADDR;
   logic [DW-1:0]   RDATA;
   logic            busy, proto_err;
   logic [2:0]      grant;

   axi_read_scheduler #(.MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rdata(m_rdata),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
      .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
      .busy(busy), .grant(grant), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {int m; logic [31:0] d; logic last;} rexp_t;
   typedef struct {logic [3:0] id; logic [AW-1:0] a; logic [3:0] len;} arexp_t;
   rexp_t  rq[$];
   arexp_t aq[$];
   rexp_t  re;
   arexp_t ae;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: no response within bound, required one", name);
   endtask

   // Monitor: every beat handshake and AR handshake is checked against the queues.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < M; i++) begin
            if (m_rvalid[i] && m_rready[i]) begin
               if (rq.size() == 0) begin
                  n_checks++;
                  $display("FAIL unexpected_beat: master %0d data %0h, required none", i, m_rdata);
               end else begin
                  re = rq.pop_front();
                  chk("r_master", 64'(i), 64'(re.m));
                  chk("r_data", 64'(m_rdata), 64'(re.d));
                  chk("r_last", 64'(m_rlast[i]), 64'(re.last));
               end
            end
         end
         if (ARVALID && ARREADY) begin
            if (aq.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_ar: id %0d addr %0h, required none", ARID, ARADDR);
            end else begin
               ae = aq.pop_front();
               chk("ar_id", 64'(ARID), 64'(ae.id));
               chk("ar_addr", 64'(ARADDR), 64'(ae.a));
               chk("ar_len", 64'(ARLEN), 64'(ae.len));
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic set_req(input int m, input logic [AW-1:0] a, input logic [3:0] len);
      m_araddr[m*AW +: AW] = a;
      m_arlen[m*4 +: 4]    = len;
      m_arvalid[m]         = 1'b1;
   endtask

   // Raise a request and wait for its m_arready; returns at posedge+1 after the grant.
   task automatic request(input int m, input logic [AW-1:0] a, input logic [3:0] len,
                          output int pulses);
      set_req(m, a, len);
      aq.push_back('{id: 4'(m), a: a, len: len});
      pulses = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (m_arready[m]) begin
            pulses++;
            break;
         end
         @(posedge clk); #1;
      end
      if (pulses == 0) fail_now("request_grant");
      @(posedge clk); #1;
      m_arvalid[m] = 1'b0;
   endtask

   // AXI slave AR side: ARREADY high in cycle delay+1 of ARVALID.
   task automatic ar_slave(input int delay, output int hi);
      bit found = 0;
      hi = 0;
      for (int n = 0; n < 50; n++) begin
         if (ARVALID) begin
            found = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!found) begin
         fail_now("arvalid_wait");
         return;
      end
      for (int k = 1; k <= delay + 1; k++) begin
         ARREADY = (k == delay + 1);
         @(negedge clk);
         if (ARVALID) hi++;
         if (k == 1) chk("arready_quiet_in_addr", 64'(m_arready), 64'd0);
         @(posedge clk); #1;
      end
      ARREADY = 1'b0;
   endtask

   // One R beat; optionally hold the owner's m_rready low for 'hold' cycles first.
   task automatic beat(input int id, input logic [31:0] d, input logic last, input int hold);
      bit ok = 0;
      RVALID = 1'b1;
      RID    = 4'(id);
      RDATA  = d;
      RLAST  = last;
      if (hold > 0) begin
         m_rready[id] = 1'b0;
         repeat (hold) begin
            @(negedge clk);
            chk("rready_backpressure", 64'(RREADY), 64'd0);
            chk("rvalid_during_stall", 64'(m_rvalid[id]), 64'd1);
            @(posedge clk); #1;
         end
         m_rready[id] = 1'b1;
      end
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (RREADY) begin
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) fail_now("rready_wait");
      if (id >= M) chk("dropped_rvalid", 64'(m_rvalid), 64'd0);
      @(posedge clk); #1;
      RVALID = 1'b0;
      RLAST  = 1'b0;
   endtask

   task automatic send(input int id, input logic [31:0] d, input logic last);
      rq.push_back('{m: id, d: d, last: last});
      beat(id, d, last, 0);
   endtask

   // Both masters request continuously; grants must alternate from 'first'.
   task automatic rr_bursts(input int n, input int first);
      int hi, e;
      set_req(0, 26'h0000400, 4'd0);
      set_req(1, 26'h0000800, 4'd0);
      for (int k = 0; k < n; k++) begin
         e = first ^ (k & 1);
         for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (|m_arready) break;
            @(posedge clk); #1;
         end
         chk("rr_arready", 64'(m_arready), 64'(1 << e));
         aq.push_back('{id: 4'(e), a: (e == 0) ? 26'h0000400 : 26'h0000800, len: 4'd0});
         @(posedge clk); #1;
         chk("rr_grant", 64'(grant), 64'(e));
         ar_slave(0, hi);
         send(e, 32'hA000 + 32'(k), 1'b1);
      end
      m_arvalid = '0;
   endtask

   initial begin
      int p, hi;
      rst = 1'b1; m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_rready = '1;
      ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RID = 4'd0; RDATA = '0;

      // Reset values
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_arvalid", 64'(ARVALID), 64'd0);
      chk("rst_rready", 64'(RREADY), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_proto_err", 64'(proto_err), 64'd0);
      chk("rst_araddr", 64'(ARADDR), 64'd0);
      chk("rst_arlen", 64'(ARLEN), 64'd0);
      chk("rst_arid", 64'(ARID), 64'd0);
      chk("rst_m_rvalid", 64'(m_rvalid | m_rlast | m_arready), 64'd0);
      do_reset();

      // Single master 0 burst, len 3, ARREADY after 2 cycles
      request(0, 26'h0000100, 4'd3, p);
      chk("t1_arready_pulses", 64'(p), 64'd1);
      ar_slave(2, hi);
      chk("t1_arvalid_cycles", 64'(hi), 64'd3);
      for (int i = 0; i < 4; i++) send(0, 32'hD0D0_0000 + 32'(i), i == 3);
      @(negedge clk);
      chk("t1_busy", 64'(busy), 64'd0);
      chk("t1_proto_err", 64'(proto_err), 64'd0);
      @(posedge clk); #1;

      // rr_ptr is now 1: master 1 wins when both request
      rr_bursts(1, 1);
      do_reset();
      rr_bursts(4, 0);

      // Backpressure on master 1
      request(1, 26'h0000200, 4'd2, p);
      ar_slave(0, hi);
      for (int i = 0; i < 3; i++) begin
         rq.push_back('{m: 1, d: 32'hB000 + 32'(i), last: i == 2});
         beat(1, 32'hB000 + 32'(i), i == 2, (i == 1) ? 3 : 0);
      end
      @(negedge clk);
      chk("t3_proto_err", 64'(proto_err), 64'd0);
      chk("t3_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;

      // Early RLAST on beat 2 of a len 3 burst
      do_reset();
      request(0, 26'h0000300, 4'd3, p);
      ar_slave(0, hi);
      send(0, 32'hC000, 1'b0);
      send(0, 32'hC001, 1'b1);
      @(negedge clk);
      chk("t4_proto_err", 64'(proto_err), 64'd1);
      chk("t4_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;

      // Foreign RID beat dropped
      do_reset();
      request(0, 26'h0000340, 4'd0, p);
      ar_slave(0, hi);
      beat(3, 32'hDEAD_BEEF, 1'b0, 0);
      @(negedge clk);
      chk("t5_proto_err", 64'(proto_err), 64'd1);
      chk("t5_still_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      send(0, 32'hC0C0, 1'b1);
      @(negedge clk);
      chk("t5_busy_after", 64'(busy), 64'd0);
      @(posedge clk); #1;

      // Reset mid-burst to master 1
      request(1, 26'h0000380, 4'd3, p);
      ar_slave(0, hi);
      send(1, 32'hE000, 1'b0);
      rst = 1'b1; RVALID = 1'b1; RID = 4'd1; RDATA = 32'hE001;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t6_arvalid", 64'(ARVALID), 64'd0);
      chk("t6_rready", 64'(RREADY), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_proto_err", 64'(proto_err), 64'd0);
      chk("t6_grant", 64'(grant), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rready_after", 64'(RREADY), 64'd0);
      chk("t6_rvalid_after", 64'(m_rvalid), 64'd0);
      @(posedge clk); #1;
      RVALID = 1'b0;

      // Master 1 withdraws as master 0's burst completes; master 0 re-granted
      request(0, 26'h00003C0, 4'd0, p);
      set_req(1, 26'h00003E0, 4'd0);
      ar_slave(0, hi);
      m_arvalid[1] = 1'b0;
      set_req(0, 26'h00003D0, 4'd0);
      send(0, 32'hF000, 1'b1);
      @(negedge clk);
      chk("t7_arready", 64'(m_arready), 64'd1);
      aq.push_back('{id: 4'd0, a: 26'h00003D0, len: 4'd0});
      @(posedge clk); #1;
      m_arvalid = '0;
      ar_slave(0, hi);
      send(0, 32'hF001, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("t7_idle_busy", 64'(busy), 64'd0);
         chk("t7_idle_arready", 64'(m_arready), 64'd0);
         @(posedge clk); #1;
      end

      chk("r_queue_drained", 64'(rq.size()), 64'd0);
      chk("ar_queue_drained", 64'(aq.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end
endmodule
